apb_mem_slave: RTL and testbench

APB4 completer with parametrised width and depth, backed by a word-addressed memory. It replaces the fixed always-ready, always-error default slave used as a bus terminator and test target. It adds the following:
- configurable wait states
- byte-strobe writes
- address decode with real error responses (out-of-range, misaligned)
- transfer abort handling
It sits on one APB select line behind the bus decoder and serves as both a scratch memory and a protocol-compliant test target for the APB UVC.

---
 rtl/apb_mem_slave.sv | 130 +++++++++++++
 tb/tb_apb_mem_slave.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB4 completer backed by a word-addressed memory: configurable wait states,
// byte-strobe writes, decode errors (out-of-range / misaligned) and abort handling.
module apb_mem_slave #(
  parameter int addrWidth  = 32,
  parameter int dataWidth  = 32,
  parameter int memDepth   = 256,
  parameter int waitStates = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [addrWidth-1:0]   paddr,
  input  logic                   pwrite,
  input  logic                   psel,
  input  logic                   penable,
  input  logic [dataWidth-1:0]   pwdata,
  input  logic [dataWidth/8-1:0] pstrb,
  output logic [dataWidth-1:0]   prdata,
  output logic                   pready,
  output logic                   pslverr
);

  localparam int nLanes   = dataWidth / 8;
  localparam int byteBits = $clog2(nLanes);
  localparam int idxBits  = $clog2(memDepth);
  localparam int idxTop   = byteBits + idxBits;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t               r_state, w_state_nxt;
  logic [3:0]           r_cnt;
  logic                 r_write;
  logic                 r_err;
  logic [idxBits-1:0]   r_idx;
  logic [dataWidth-1:0] r_prdata;
  logic [dataWidth-1:0] r_mem [memDepth];

  logic [idxBits-1:0]   w_idx;
  logic                 w_misalign;
  logic                 w_range;
  logic                 w_err;
  logic                 w_setup;
  logic                 w_wr_en;
  logic                 w_pready;
  logic                 w_pslverr;

  assign w_idx = paddr[byteBits +: idxBits];

  // Any address bit above the index field means the word lies past memDepth.
  generate
    if (byteBits > 0) begin : g_align
      assign w_misalign = |paddr[byteBits-1:0];
    end else begin : g_noalign
      assign w_misalign = 1'b0;
    end
    if (addrWidth > idxTop) begin : g_range
      assign w_range = |paddr[addrWidth-1:idxTop];
    end else begin : g_norange
      assign w_range = 1'b0;
    end
  endgenerate

  assign w_err   = w_misalign | w_range;
  assign w_setup = psel & ~penable;

  always_comb begin
    w_state_nxt = r_state;
    w_pready    = 1'b0;
    w_pslverr   = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_setup) w_state_nxt = ACCESS;
      end
      ACCESS: begin
        w_pready  = (r_cnt == '0);
        w_pslverr = w_pready & r_err;
        if (!psel) begin
          w_state_nxt = IDLE;
        end else if (penable && r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_wr_en     = r_write & ~r_err & ~rst;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= '0;
      r_prdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_write  <= pwrite;
            r_idx    <= w_idx;
            r_err    <= w_err;
            r_cnt    <= 4'(waitStates);
            r_prdata <= (!pwrite && !w_err) ? r_mem[w_idx] : '0;
          end
        end
        ACCESS: begin
          if (psel && penable && r_cnt != '0) r_cnt <= r_cnt - 4'd1;
          if (w_state_nxt == IDLE) r_prdata <= '0;
        end
        default: ;
      endcase
    end
  end

  // Write data and strobes are taken at the completion edge, not at setup.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int unsigned b = 0; b < nLanes; b++) begin
        if (pstrb[b]) r_mem[r_idx][8*b +: 8] <= pwdata[8*b +: 8];
      end
    end
  end

  assign prdata  = r_prdata;
  assign pready  = w_pready;
  assign pslverr = w_pslverr;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: three instances (0, 3 and 2 wait states)
// share the bus signals and have individual select lines.
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr;
  logic        pwrite;
  logic [2:0]  psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata [3];
  logic [2:0]  pready;
  logic [2:0]  pslverr;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  apb_mem_slave #(.addrWidth(32), .dataWidth(32), .memDepth(256), .waitStates(0)) u_ws0 (
    .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel[0]),
    .penable(penable), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]));

  apb_mem_slave #(.addrWidth(32), .dataWidth(32), .memDepth(256), .waitStates(3)) u_ws3 (
    .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel[1]),
    .penable(penable), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]));

  apb_mem_slave #(.addrWidth(32), .dataWidth(32), .memDepth(256), .waitStates(2)) u_ws2 (
    .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel[2]),
    .penable(penable), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[2]),
    .pready(pready[2]), .pslverr(pslverr[2]));

  // Setup + access phase; leaves psel/penable high so a following call is back-to-back.
  task automatic xfer(input int d, input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic err, output int waits);
    @(negedge clk);
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    paddr = a; pwrite = w; pwdata = wd; pstrb = st;
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    while (pready[d] !== 1'b1 && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    rd  = prdata[d];
    err = pslverr[d];
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel = '0; penable = 1'b0; pwrite = 1'b0; pstrb = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; psel = '0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (pready[i] !== 1'b0 || pslverr[i] !== 1'b0 || prdata[i] !== 32'h0)
        $display("FAIL reset dut%0d: pready=%b pslverr=%b prdata=%h, required 0/0/0",
                 i, pready[i], pslverr[i], prdata[i]);
      else passed++;
    end
  endtask

  task automatic test_ws0();
    logic [31:0] rd; logic err; int waits;
    xfer(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, rd, err, waits);
    total++;
    if (waits !== 0 || err !== 1'b0)
      $display("FAIL ws0_write: waits=%0d err=%b, required 0/0", waits, err);
    else passed++;
    xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, rd, err, waits);
    total++;
    if (waits !== 0 || err !== 1'b0 || rd !== 32'hDEADBEEF)
      $display("FAIL ws0_read: waits=%0d err=%b rd=%h, required 0/0/deadbeef", waits, err, rd);
    else passed++;
    bus_idle();
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic err; int waits;
    xfer(0, 32'h20, 1'b1, 32'h11223344, 4'hF, rd, err, waits);
    xfer(0, 32'h20, 1'b1, 32'hAABBCCDD, 4'h5, rd, err, waits);
    xfer(0, 32'h20, 1'b0, 32'h0, 4'h0, rd, err, waits);
    total++;
    if (rd !== 32'h11BB33DD || err !== 1'b0)
      $display("FAIL strobe: rd=%h err=%b, required 11bb33dd/0", rd, err);
    else passed++;
    xfer(0, 32'h20, 1'b1, 32'h00000099, 4'h8, rd, err, waits);
    xfer(0, 32'h20, 1'b0, 32'h0, 4'h0, rd, err, waits);
    total++;
    if (rd !== 32'h00BB33DD)
      $display("FAIL strobe_top_lane: rd=%h, required 00bb33dd", rd);
    else passed++;
    bus_idle();
  endtask

  task automatic test_wait3();
    logic [31:0] rd; logic err; int waits; int bad;
    xfer(1, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, rd, err, waits);
    total++;
    if (waits !== 3) $display("FAIL ws3_write_waits: waits=%0d, required 3", waits);
    else passed++;
    @(negedge clk);
    psel = 3'b010; penable = 1'b0; paddr = 32'h10; pwrite = 1'b0; pstrb = '0;
    @(negedge clk);
    penable = 1'b1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (pready[1] !== (c == 3)) bad++;
      if (prdata[1] !== 32'hDEADBEEF) bad++;
      pwdata = 32'h1111 * c;
      paddr  = 32'h20;
      if (c < 3) @(negedge clk);
    end
    total++;
    if (bad !== 0 || pslverr[1] !== 1'b0)
      $display("FAIL ws3_read: bad_cycles=%0d pslverr=%b, required 0/0", bad, pslverr[1]);
    else passed++;
    @(negedge clk);
    total++;
    if (pready[1] !== 1'b0 || prdata[1] !== 32'h0)
      $display("FAIL ws3_after: pready=%b prdata=%h, required 0/0", pready[1], prdata[1]);
    else passed++;
    psel = '0; penable = 1'b0;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int waits;
    xfer(0, 32'h0,   1'b1, 32'hCAFEF00D, 4'hF, rd, err, waits);
    xfer(0, 32'h3FC, 1'b1, 32'h12345678, 4'hF, rd, err, waits);
    xfer(0, 32'h400, 1'b1, 32'hFFFFFFFF, 4'hF, rd, err, waits);
    total++;
    if (err !== 1'b1 || waits !== 0)
      $display("FAIL err_write_range: err=%b waits=%0d, required 1/0", err, waits);
    else passed++;
    xfer(0, 32'h11, 1'b1, 32'h0, 4'hF, rd, err, waits);
    total++;
    if (err !== 1'b1) $display("FAIL err_write_misalign: err=%b, required 1", err);
    else passed++;
    xfer(0, 32'h0, 1'b0, 32'h0, 4'h0, rd, err, waits);
    total++;
    if (rd !== 32'hCAFEF00D || err !== 1'b0)
      $display("FAIL err_mem0_kept: rd=%h err=%b, required cafef00d/0", rd, err);
    else passed++;
    xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, rd, err, waits);
    total++;
    if (rd !== 32'hDEADBEEF) $display("FAIL err_mem10_kept: rd=%h, required deadbeef", rd);
    else passed++;
    xfer(0, 32'h402, 1'b0, 32'h0, 4'h0, rd, err, waits);
    total++;
    if (err !== 1'b1 || rd !== 32'h0)
      $display("FAIL err_read_402: err=%b rd=%h, required 1/0", err, rd);
    else passed++;
    xfer(0, 32'h3FC, 1'b0, 32'h0, 4'h0, rd, err, waits);
    total++;
    if (err !== 1'b0 || rd !== 32'h12345678)
      $display("FAIL err_read_3fc: err=%b rd=%h, required 0/12345678", err, rd);
    else passed++;
    bus_idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int waits;
    xfer(2, 32'h30, 1'b1, 32'h55AA55AA, 4'hF, rd, err, waits);
    total++;
    if (waits !== 2) $display("FAIL ws2_write_waits: waits=%0d, required 2", waits);
    else passed++;
    @(negedge clk);
    psel = 3'b100; penable = 1'b0; paddr = 32'h30; pwrite = 1'b1;
    pwdata = 32'h0; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = '0; penable = 1'b0;
    @(negedge clk);
    total++;
    if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0)
      $display("FAIL abort_idle: pready=%b pslverr=%b, required 0/0", pready[2], pslverr[2]);
    else passed++;
    repeat (3) @(negedge clk);
    xfer(2, 32'h30, 1'b0, 32'h0, 4'h0, rd, err, waits);
    total++;
    if (rd !== 32'h55AA55AA || waits !== 2)
      $display("FAIL abort_mem: rd=%h waits=%0d, required 55aa55aa/2", rd, waits);
    else passed++;
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int waits;
    xfer(2, 32'h40, 1'b1, 32'h0BADF00D, 4'hF, rd, err, waits);
    xfer(2, 32'h40, 1'b0, 32'h0, 4'h0, rd, err, waits);
    // Read outstanding with prdata loaded, then an abandoned write at its completion edge.
    xfer(1, 32'h10, 1'b0, 32'h0, 4'h0, rd, err, waits);
    bus_idle();
    @(negedge clk);
    psel = 3'b100; penable = 1'b0; paddr = 32'h40; pwrite = 1'b1;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (pready[2] !== 1'b1) $display("FAIL rst_mid_pre: pready=%b, required 1", pready[2]);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0 || prdata[2] !== 32'h0)
      $display("FAIL rst_mid_outputs: pready=%b pslverr=%b prdata=%h, required 0/0/0",
               pready[2], pslverr[2], prdata[2]);
    else passed++;
    rst = 1'b0; psel = '0; penable = 1'b0;
    xfer(2, 32'h40, 1'b0, 32'h0, 4'h0, rd, err, waits);
    total++;
    if (rd !== 32'h0BADF00D || err !== 1'b0 || waits !== 2)
      $display("FAIL rst_mid_mem: rd=%h err=%b waits=%0d, required 0badf00d/0/2", rd, err, waits);
    else passed++;
    bus_idle();
  endtask

  task automatic test_stray_enable();
    logic [31:0] rd; logic err; int waits;
    @(negedge clk);
    psel = 3'b001; penable = 1'b1; paddr = 32'h10; pwrite = 1'b0;
    @(negedge clk);
    total++;
    if (pready[0] !== 1'b0) $display("FAIL stray_enable: pready=%b, required 0", pready[0]);
    else passed++;
    xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, rd, err, waits);
    total++;
    if (rd !== 32'hDEADBEEF || waits !== 0)
      $display("FAIL stray_then_read: rd=%h waits=%0d, required deadbeef/0", rd, waits);
    else passed++;
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_ws0();
    test_strobe();
    test_wait3();
    test_errors();
    test_abort();
    test_reset_mid();
    test_stray_enable();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
